edge_synth: RTL and testbench

EDGE_SYNTH -- requirements
Module: edge_synth

---
 rtl/edge_synth_pkg.sv | 21 ++
 rtl/edge_synth_hold.sv | 28 ++
 rtl/edge_synth.sv | 117 +++++++++++
 tb/tb_edge_synth.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_synth_pkg.sv
// Shared types and constants for the edge synthesizer: state encoding,
// hold counter width and the default minimum hold length.
package edge_synth_pkg;

  localparam int MIN_HOLD_DEFAULT = 4;
  localparam int HOLD_W           = 8;

  // Bit 0 is the output level and bit 1 marks a hold interval, so both
  // d_out and busy come straight from state flops.
  typedef enum logic [1:0] {
    LOW       = 2'b00,
    HIGH      = 2'b01,
    LOW_HOLD  = 2'b10,
    HIGH_HOLD = 2'b11
  } edge_state_t;

  function automatic edge_state_t hold_state(input logic level);
    return level ? HIGH_HOLD : LOW_HOLD;
  endfunction

endpackage

// File: rtl/edge_synth_hold.sv
// Hold interval counter: loadable down-counter that stops at zero and
// reports a zero flag.
module hold_counter
  import edge_synth_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  logic [HOLD_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/edge_synth.sv
// Edge synthesizer: turns rise/fall requests into a level that holds at least
// MIN_HOLD cycles per edge, queuing one opposite request. Optional err_cnt
// port is compiled in with EDGE_SYNTH_ERR_CNT_EN.
module edge_synth
  import edge_synth_pkg::*;
#(
  parameter int MIN_HOLD  = MIN_HOLD_DEFAULT,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rise_req,
  input  logic                 fall_req,
  output logic                 d_out,
  output logic                 busy,
  output logic                 pending,
  output logic                 err,
`ifdef EDGE_SYNTH_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0] err_cnt,
`endif
  output logic [1:0]           state
);

  if (MIN_HOLD < 1 || MIN_HOLD > 255 || ERR_CNT_W < 1) begin : g_bad_param
    $error("edge_synth: MIN_HOLD must be 1..255 and ERR_CNT_W at least 1");
  end

  localparam logic [HOLD_W-1:0] RELOAD = HOLD_W'(MIN_HOLD - 1);

  edge_state_t cur_state;
  edge_state_t next_state;
  logic        pend_q;
  logic        pend_d;
  logic        err_d;
  logic        load;
  logic        zero;
  logic        level;
  logic        any_req;
  logic        opp_req;
  logic        accept;

  // Request classification: only a lone request for the opposite level is
  // ever accepted, and only while the single queue slot is free.
  assign level   = cur_state[0];
  assign any_req = rise_req | fall_req;
  assign opp_req = (rise_req ^ fall_req) && (level ? fall_req : rise_req);
  assign accept  = opp_req && !pend_q;

  hold_counter u_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (RELOAD),
    .dec      (cur_state[1]),
    .zero     (zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= LOW;
      pend_q    <= 1'b0;
      err       <= 1'b0;
    end else begin
      cur_state <= next_state;
      pend_q    <= pend_d;
      err       <= err_d;
    end
  end

  always_comb begin
    next_state = cur_state;
    pend_d     = pend_q;
    load       = 1'b0;
    err_d      = any_req && !accept;
    case (cur_state)
      LOW, HIGH: begin
        if (accept) begin
          next_state = hold_state(!level);
          load       = 1'b1;
        end
      end
      default: begin
        // A request landing on the last hold cycle toggles at the very next
        // edge, exactly as if it had been queued earlier.
        if (zero) begin
          if (pend_q || accept) begin
            next_state = hold_state(!level);
            load       = 1'b1;
            pend_d     = 1'b0;
          end else begin
            next_state = level ? HIGH : LOW;
          end
        end else if (accept) begin
          pend_d = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    d_out   = cur_state[0];
    busy    = cur_state[1];
    pending = pend_q;
    state   = cur_state;
  end

`ifdef EDGE_SYNTH_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (err_d && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_edge_synth.sv
// Bench for edge_synth: two instances (MIN_HOLD 4 and 1) driven in lockstep,
// checked every cycle against a level/age model plus literal expectations.
module tb_edge_synth;
  import edge_synth_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rise = 1'b0;
  logic       fall = 1'b0;
  logic       d_o [2];
  logic       bsy [2];
  logic       pnd [2];
  logic       er  [2];
  logic [1:0] st  [2];
`ifdef EDGE_SYNTH_ERR_CNT_EN
  logic [7:0] ec  [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model: current level, cycles shown at that level since the last edge,
  // one queued opposite request, err pulse, accepted count, err count.
  int   m_hold [2] = '{4, 1};
  logic m_level [2];
  int   m_age [2];
  logic m_q [2];
  logic m_err [2];
  int   m_acc [2];
  int   m_ecnt [2];

  always #5 clk = ~clk;

  edge_synth #(.MIN_HOLD(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .rise_req(rise), .fall_req(fall),
    .d_out(d_o[0]), .busy(bsy[0]), .pending(pnd[0]), .err(er[0]),
`ifdef EDGE_SYNTH_ERR_CNT_EN
    .err_cnt(ec[0]),
`endif
    .state(st[0])
  );

  edge_synth #(.MIN_HOLD(1), .ERR_CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .rise_req(rise), .fall_req(fall),
    .d_out(d_o[1]), .busy(bsy[1]), .pending(pnd[1]), .err(er[1]),
`ifdef EDGE_SYNTH_ERR_CNT_EN
    .err_cnt(ec[1]),
`endif
    .state(st[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input logic rst, input logic r, input logic f);
    logic opp;
    logic acc;
    if (rst) begin
      m_level[i] = 1'b0;
      m_age[i]   = m_hold[i] + 1;
      m_q[i]     = 1'b0;
      m_err[i]   = 1'b0;
      m_ecnt[i]  = 0;
      return;
    end
    opp = (r != f) && (m_level[i] ? f : r);
    acc = opp && !m_q[i];
    m_err[i] = (r || f) && !acc;
    if (m_err[i] && m_ecnt[i] < 255) m_ecnt[i]++;
    if (acc) m_acc[i]++;
    if (m_age[i] > m_hold[i]) begin
      if (acc) begin
        m_level[i] = !m_level[i];
        m_age[i]   = 1;
      end
    end else if (m_age[i] == m_hold[i]) begin
      if (m_q[i] || acc) begin
        m_level[i] = !m_level[i];
        m_age[i]   = 1;
        m_q[i]     = 1'b0;
      end else begin
        m_age[i] = m_hold[i] + 1;
      end
    end else begin
      if (acc) m_q[i] = 1'b1;
      m_age[i]++;
    end
  endtask

  function automatic int exp_state(input int i);
    if (m_age[i] <= m_hold[i]) return m_level[i] ? int'(HIGH_HOLD) : int'(LOW_HOLD);
    return m_level[i] ? int'(HIGH) : int'(LOW);
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("m%0d_d_out", i), int'(d_o[i]), int'(m_level[i]));
        chk($sformatf("m%0d_busy", i), int'(bsy[i]), int'(m_age[i] <= m_hold[i]));
        chk($sformatf("m%0d_pending", i), int'(pnd[i]), int'(m_q[i]));
        chk($sformatf("m%0d_err", i), int'(er[i]), int'(m_err[i]));
        chk($sformatf("m%0d_state", i), int'(st[i]), exp_state(i));
`ifdef EDGE_SYNTH_ERR_CNT_EN
        chk($sformatf("m%0d_err_cnt", i), int'(ec[i]), m_ecnt[i]);
`endif
      end
    end
  end

  task automatic cyc(input logic r, input logic f);
    rise = r;
    fall = f;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, reset, r, f);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0);
  endtask

  int  run_len;
  int  short_runs;
  int  edges0;
  int  edges1;
  bit  first_run;
  logic prev0;
  logic prev1;
  int  acc0_base;
  int  acc1_base;

  task automatic detect();
    if (d_o[1] != prev1) begin
      edges1++;
      prev1 = d_o[1];
    end
    if (d_o[0] == prev0) begin
      run_len++;
    end else begin
      if (!first_run && run_len < 4) short_runs++;
      first_run = 1'b0;
      run_len   = 1;
      edges0++;
      prev0 = d_o[0];
    end
  endtask

  initial begin
    do_reset();
    cmp_en = 1'b1;
    chk("reset_d_out", int'(d_o[0]), 0);
    chk("reset_busy", int'(bsy[0]), 0);
    chk("reset_pending", int'(pnd[0]), 0);
    chk("reset_err", int'(er[0]), 0);
    chk("reset_state", int'(st[0]), 0);

    // Rise then idle: high from cycle 1, busy 1..4, settled HIGH at 5.
    cyc(1'b1, 1'b0);
    chk("rise_c1_d_out", int'(d_o[0]), 1);
    chk("rise_c1_busy", int'(bsy[0]), 1);
    chk("rise_c1_mh1_state", int'(st[1]), 3);
    idle(3);
    chk("rise_c4_busy", int'(bsy[0]), 1);
    cyc(1'b0, 1'b0);
    chk("rise_c5_busy", int'(bsy[0]), 0);
    chk("rise_c5_state", int'(st[0]), 1);

    // Fall queued during the hold: pending 3..4, low at 5.
    do_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("queue_c3_pending", int'(pnd[0]), 1);
    cyc(1'b0, 1'b0);
    chk("queue_c4_pending", int'(pnd[0]), 1);
    chk("queue_c4_d_out", int'(d_o[0]), 1);
    cyc(1'b0, 1'b0);
    chk("queue_c5_d_out", int'(d_o[0]), 0);
    chk("queue_c5_pending", int'(pnd[0]), 0);
    chk("queue_c5_state", int'(st[0]), 2);

    // Both requests together in LOW are rejected.
    do_reset();
    cyc(1'b1, 1'b1);
    chk("both_err", int'(er[0]), 1);
    chk("both_d_out", int'(d_o[0]), 0);
`ifdef EDGE_SYNTH_ERR_CNT_EN
    chk("both_err_cnt", int'(ec[0]), 1);
`endif
    cyc(1'b0, 1'b0);
    chk("both_err_clear", int'(er[0]), 0);

    // Fall in LOW rejected, rise accepted, fall queued, rise rejected.
    do_reset();
    cyc(1'b0, 1'b1);
    chk("seq_c1_err", int'(er[0]), 1);
    cyc(1'b1, 1'b0);
    chk("seq_c2_d_out", int'(d_o[0]), 1);
    chk("seq_c2_err", int'(er[0]), 0);
    cyc(1'b0, 1'b1);
    chk("seq_c3_pending", int'(pnd[0]), 1);
    cyc(1'b1, 1'b0);
    chk("seq_c4_err", int'(er[0]), 1);
    idle(2);
    chk("seq_c6_d_out", int'(d_o[0]), 0);
    idle(4);
    chk("seq_c10_state", int'(st[0]), 0);

    // Reset in the middle of a hold with a queued request.
    do_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk("rst_mid_pending_before", int'(pnd[0]), 1);
    reset = 1'b1;
    cyc(1'b0, 1'b0);
    reset = 1'b0;
    chk("rst_mid_d_out", int'(d_o[0]), 0);
    chk("rst_mid_pending", int'(pnd[0]), 0);
    chk("rst_mid_busy", int'(bsy[0]), 0);
    chk("rst_mid_state", int'(st[0]), 0);

    // Opposite request on the last hold cycle toggles at the next edge.
    do_reset();
    cyc(1'b1, 1'b0);
    idle(3);
    cyc(1'b0, 1'b1);
    chk("last_cycle_d_out", int'(d_o[0]), 0);
    chk("last_cycle_state", int'(st[0]), 2);
    chk("last_cycle_err", int'(er[0]), 0);

    // Alternating requests: MIN_HOLD=1 toggles every cycle.
    do_reset();
    cyc(1'b1, 1'b0);
    chk("alt_c1_mh1", int'(d_o[1]), 1);
    cyc(1'b0, 1'b1);
    chk("alt_c2_mh1", int'(d_o[1]), 0);
    cyc(1'b1, 1'b0);
    chk("alt_c3_mh1", int'(d_o[1]), 1);
    chk("alt_c3_mh4_err", int'(er[0]), 1);
    cyc(1'b0, 1'b1);
    chk("alt_c4_mh1", int'(d_o[1]), 0);
    idle(6);

    // Random requests with a level-length detector on d_out.
    do_reset();
    acc0_base  = m_acc[0];
    acc1_base  = m_acc[1];
    run_len    = 1;
    short_runs = 0;
    edges0     = 0;
    edges1     = 0;
    first_run  = 1'b1;
    prev0      = d_o[0];
    prev1      = d_o[1];
    for (int k = 0; k < 80; k++) begin
      cyc(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 2) == 0));
      detect();
    end
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0);
      detect();
    end
    chk("rand_short_levels", short_runs, 0);
    chk("rand_edges_vs_accepted_mh4", edges0, m_acc[0] - acc0_base);
    chk("rand_edges_vs_accepted_mh1", edges1, m_acc[1] - acc1_base);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion before 200000");
    $fatal(1, "watchdog");
  end

endmodule
